// File: rtl/nn_job_scheduler.sv
// Job scheduler around the nn inference block: issues one job at a time with fixed
// spacing, captures the result after the nn pipeline latency and queues it in a show-ahead FIFO.
module nn_job_scheduler #(
  parameter int DATAWIDTH  = 32,
  parameter int LOAD_WAIT  = 10,
  parameter int NN_LATENCY = 5,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTW       = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATAWIDTH-1:0]            in_data_1,
  input  logic [DATAWIDTH-1:0]            in_data_2,
  output logic                            nn_enable,
  output logic [DATAWIDTH-1:0]            nn_input_1,
  output logic [DATAWIDTH-1:0]            nn_input_2,
  input  logic [DATAWIDTH-1:0]            nn_final_output,
  input  logic                            nn_total_ovf,
  input  logic                            nn_total_zero,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATAWIDTH-1:0]            out_data,
  output logic                            out_ovf,
  output logic                            out_zero,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic [CNTW-1:0]                 job_count,
  output logic [CNTW-1:0]                 ovf_count
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int FCW  = $clog2(FIFO_DEPTH+1);
  localparam int TMRW = 16;

  typedef enum logic [2:0] {
    S_WAIT_LOAD,
    S_IDLE,
    S_ISSUE,
    S_WAIT_RES,
    S_GAP
  } state_e;

  typedef struct packed {
    logic [DATAWIDTH-1:0] data;
    logic                 ovf;
    logic                 zero;
  } entry_t;

  state_e               state_q, state_d;
  logic [TMRW-1:0]      tmr_q, tmr_d;
  logic                 nn_enable_q, nn_enable_d;
  logic [DATAWIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]       count_q, count_d;
  logic [CNTW-1:0]      job_q, job_d, ovf_q, ovf_d;
  logic                 push, pop;
  entry_t               mem [FIFO_DEPTH];

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    nn_enable_d = 1'b0;
    in1_d       = in1_q;
    in2_d       = in2_q;
    push        = 1'b0;
    in_ready    = (state_q == S_IDLE) && (count_q < FCW'(FIFO_DEPTH));
    case (state_q)
      S_WAIT_LOAD: begin
        if (tmr_q == TMRW'(LOAD_WAIT - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMRW'(1);
        end
      end
      S_IDLE: begin
        if (in_valid && in_ready) begin
          in1_d       = in_data_1;
          in2_d       = in_data_2;
          nn_enable_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_RES;
        tmr_d   = '0;
      end
      S_WAIT_RES: begin
        // The last WAIT_RES edge is the one where nn's final_output is valid.
        if (tmr_q == TMRW'(NN_LATENCY)) begin
          push    = 1'b1;
          state_d = S_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMRW'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == TMRW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMRW'(1);
        end
      end
      default: state_d = S_WAIT_LOAD;
    endcase
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    job_d    = job_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
    if (push && !pop)      count_d = count_q + FCW'(1);
    else if (!push && pop) count_d = count_q - FCW'(1);
    if (push && (job_q != '1)) job_d = job_q + CNTW'(1);
    if (push && nn_total_ovf && (ovf_q != '1)) ovf_d = ovf_q + CNTW'(1);
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_WAIT_LOAD;
      tmr_q       <= '0;
      nn_enable_q <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      job_q       <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      nn_enable_q <= nn_enable_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      job_q       <= job_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: FIFO storage is not reset; the head is gated by out_valid, so stale entries never reach out_*.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{data: nn_final_output, ovf: nn_total_ovf, zero: nn_total_zero};
  end

  assign nn_enable  = nn_enable_q;
  assign nn_input_1 = in1_q;
  assign nn_input_2 = in2_q;
  assign out_data   = out_valid ? mem[rd_ptr_q].data : '0;
  assign out_ovf    = out_valid && mem[rd_ptr_q].ovf;
  assign out_zero   = out_valid && mem[rd_ptr_q].zero;
  assign fifo_count = count_q;
  assign job_count  = job_q;
  assign ovf_count  = ovf_q;

endmodule

// File: tb/tb_nn_job_scheduler.sv
// Directed bench for nn_job_scheduler with a windowed nn stub: the stub result is valid only
// on the one cycle the scheduler is meant to capture it, otherwise it drives junk.
module tb_nn_job_scheduler;
  localparam int DW = 32;
  localparam int NN_LATENCY = 5;
  localparam int CW = 4;  // narrow counters so saturation is reachable

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data_1 = '0, in_data_2 = '0;
  logic          nn_enable;
  logic [DW-1:0] nn_input_1, nn_input_2, nn_final_output;
  logic          nn_total_ovf, nn_total_zero;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_ovf, out_zero;
  logic [2:0]    fifo_count;
  logic [CW-1:0] job_count, ovf_count;

  always #5 clk = ~clk;

  nn_job_scheduler #(.DATAWIDTH(DW), .LOAD_WAIT(10), .NN_LATENCY(NN_LATENCY), .GAP_CYCLES(2),
                     .FIFO_DEPTH(4), .CNTW(CW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_1(in_data_1), .in_data_2(in_data_2), .nn_enable(nn_enable),
    .nn_input_1(nn_input_1), .nn_input_2(nn_input_2), .nn_final_output(nn_final_output),
    .nn_total_ovf(nn_total_ovf), .nn_total_zero(nn_total_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_zero(out_zero),
    .fifo_count(fifo_count), .job_count(job_count), .ovf_count(ovf_count)
  );

  typedef struct packed {logic [DW-1:0] d; logic o; logic z;} rsp_t;

  typedef struct {
    logic [DW-1:0] in1, in2;
    rsp_t          rsp;
    logic [DW-1:0] exp_d;
    logic          exp_o, exp_z;
  } vec_t;

  // nn stub: result valid only after the 5th edge following the enable-sampling edge
  rsp_t rsp_q[$];
  rsp_t cur_rsp;
  int   stub_cnt;
  logic stub_live;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stub_cnt <= 0;
      cur_rsp  <= '0;
    end else if (nn_enable) begin
      stub_cnt <= 1;
      cur_rsp  <= (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
    end else if (stub_cnt != 0 && stub_cnt < 1000) begin
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign stub_live       = (stub_cnt == NN_LATENCY + 1);
  assign nn_final_output = stub_live ? cur_rsp.d : 32'hDEAD_BEEF;
  assign nn_total_ovf    = stub_live ? cur_rsp.o : 1'b1;
  assign nn_total_zero   = stub_live ? cur_rsp.z : 1'b1;

  int total = 0, bad = 0;
  int max_fc = 0;
  logic mon_en = 1'b0;
  always @(negedge clk) if (mon_en && int'(fifo_count) > max_fc) max_fc = int'(fifo_count);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic send_job(input logic [DW-1:0] a, input logic [DW-1:0] b, input rsp_t r,
                          input string nm);
    int n = 0;
    in_data_1 = a;
    in_data_2 = b;
    in_valid  = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready_seen"}, in_ready, 1);
    if (in_ready) begin
      rsp_q.push_back(r);
      @(posedge clk);
      @(negedge clk);
      check({nm, "_enable"}, nn_enable, 1);
      check({nm, "_in1"}, nn_input_1, a);
      check({nm, "_in2"}, nn_input_2, b);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_fifo(input int target, input string nm);
    int n = 0;
    while (int'(fifo_count) != target && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_fifo_count"}, fifo_count, target);
  endtask

  task automatic pop_check(input logic [DW-1:0] ed, input logic eo, input logic ez, input string nm);
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_data"}, out_data, ed);
    check({nm, "_ovf"}, out_ovf, eo);
    check({nm, "_zero"}, out_zero, ez);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    int n = 0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rsp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vec[7];
    logic seen;

    vec[0] = '{32'd1, 32'd2, '{32'h1111_1111, 1'b0, 1'b0}, 32'h1111_1111, 1'b0, 1'b0};
    vec[1] = '{32'd3, 32'd4, '{32'h2222_2222, 1'b1, 1'b0}, 32'h2222_2222, 1'b1, 1'b0};
    vec[2] = '{32'd5, 32'd6, '{32'h3333_3333, 1'b0, 1'b1}, 32'h3333_3333, 1'b0, 1'b1};
    vec[3] = '{32'd7, 32'd8, '{32'h4444_4444, 1'b1, 1'b1}, 32'h4444_4444, 1'b1, 1'b1};
    vec[4] = '{32'd9, 32'd10, '{32'h5555_5555, 1'b0, 1'b0}, 32'h5555_5555, 1'b0, 1'b0};
    vec[5] = '{32'h7FFF_FFFF, 32'd1, '{32'hFFFF_FFFF, 1'b1, 1'b0}, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vec[6] = '{32'hFFFF_FFF9, 32'd7, '{32'h0000_0000, 1'b0, 1'b1}, 32'h0000_0000, 1'b0, 1'b1};

    // Reset state, load wait with in_valid held, first job
    in_valid  = 1'b1;
    in_data_1 = 32'd100;
    in_data_2 = 32'hFFFF_FFCE;
    rsp_q.push_back('{32'h0000_1234, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_nn_enable", nn_enable, 0);
    check("rst_nn_input_1", nn_input_1, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_job_count", job_count, 0);
    check("rst_ovf_count", ovf_count, 0);
    resetn = 1'b1;
    #1;
    check("load_ready_e0", in_ready, 0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("load_ready_e%0d", k), in_ready, 0);
    end
    @(negedge clk);
    check("load_ready_e10", in_ready, 1);
    @(negedge clk);
    check("j1_enable", nn_enable, 1);
    check("j1_in1", nn_input_1, 32'd100);
    check("j1_in2", nn_input_2, 32'hFFFF_FFCE);
    check("j1_busy", in_ready, 0);
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) check("j1_enable_pulse", nn_enable, 0);
      check($sformatf("j1_no_result_e%0d", k), out_valid, 0);
    end
    @(negedge clk);
    check("j1_in1_hold", nn_input_1, 32'd100);
    check("j1_fifo_count", fifo_count, 1);
    check("j1_job_count", job_count, 1);
    check("j1_ovf_count", ovf_count, 0);
    pop_check(32'h0000_1234, 1'b0, 1'b0, "j1_res");
    check("j1_fifo_empty", fifo_count, 0);

    // Fill the FIFO with out_ready low; fifth job must be held off
    for (int i = 0; i < 4; i++) send_job(vec[i].in1, vec[i].in2, vec[i].rsp, $sformatf("fill%0d", i));
    wait_fifo(4, "full");
    in_data_1 = vec[4].in1;
    in_data_2 = vec[4].in2;
    in_valid  = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | in_ready;
    end
    check("full_in_ready_low", seen, 0);
    check("full_fifo_count", fifo_count, 4);
    rsp_q.push_back(vec[4].rsp);
    check("full_head", out_data, vec[0].exp_d);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("pulse_fifo_count", fifo_count, 3);
    check("pulse_new_head", out_data, vec[1].exp_d);
    check("pulse_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("fifth_enable", nn_enable, 1);
    check("fifth_in1", nn_input_1, vec[4].in1);
    // Pop on the same edge as the fifth result's push
    repeat (6) @(negedge clk);
    check("pre_push_count", fifo_count, 3);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("pushpop_count", fifo_count, 3);
    for (int i = 2; i <= 4; i++)
      pop_check(vec[i].exp_d, vec[i].exp_o, vec[i].exp_z, $sformatf("drain%0d", i));
    check("drain_empty", fifo_count, 0);
    check("t3_job_count", job_count, 6);
    check("t3_ovf_count", ovf_count, 2);

    // Overflow code and zero flag pass through unmodified
    do_reset();
    for (int i = 5; i <= 6; i++) send_job(vec[i].in1, vec[i].in2, vec[i].rsp, $sformatf("flag%0d", i));
    wait_fifo(2, "flags");
    for (int i = 5; i <= 6; i++)
      pop_check(vec[i].exp_d, vec[i].exp_o, vec[i].exp_z, $sformatf("flag_res%0d", i));
    check("t4_job_count", job_count, 2);
    check("t4_ovf_count", ovf_count, 1);

    // Streaming with out_ready tied high; job_count saturates at 15
    out_ready = 1'b1;
    max_fc = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int n;
      rsp_t r;
      r = '{32'hA000_0000 + 32'(i * 17), (i % 2 == 0), (i == 5)};
      send_job(32'(i * 1000 + 7), 32'(i), r, $sformatf("s%0d", i));
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("s%0d_data", i), out_data, 32'hA000_0000 + 32'(i * 17));
      check($sformatf("s%0d_flags", i), {out_ovf, out_zero}, {(i % 2 == 0), (i == 5)});
      @(negedge clk);
      check($sformatf("s%0d_popped", i), fifo_count, 0);
    end
    mon_en = 1'b0;
    out_ready = 1'b0;
    check("stream_max_fifo", max_fc, 1);
    check("stream_job_sat", job_count, 15);
    check("stream_ovf_count", ovf_count, 11);

    // Reset mid-job discards everything
    send_job(32'd42, 32'd43, '{32'h0BAD_0001, 1'b1, 1'b0}, "r1");
    wait_fifo(1, "r1");
    send_job(32'd44, 32'd45, '{32'h0BAD_0002, 1'b1, 1'b0}, "r2");
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_enable", nn_enable, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_fifo", fifo_count, 0);
    check("mid_rst_jobs", job_count, 0);
    check("mid_rst_ovfs", ovf_count, 0);
    check("mid_rst_in1", nn_input_1, 0);
    rsp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    seen = in_ready;
    repeat (9) begin
      @(negedge clk);
      seen = seen | in_ready;
    end
    check("reload_ready_low", seen, 0);
    @(negedge clk);
    check("reload_ready", in_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("no_stale_result", seen, 0);
    check("no_stale_jobs", job_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
